// File: rtl/float_mul_arbiter.sv
// ---------------------------------------------------------------------------
// float_mul_arbiter
//
// Shares one multi-cycle float multiplier between NUM_REQ requesters. Only one
// transaction is in flight at a time. Requests are granted round-robin, the
// operands are latched and issued with a single load strobe, the multiplier's
// ready pulse is awaited under a watchdog, and the captured result is returned
// to the granted requester over a valid/ready handshake.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid / req_ready    per-requester request handshake (ready is a
//                            one-hot accept pulse, only in IDLE)
//   req_op_a / req_op_b      packed operand bundles, requester i at
//                            [i*OP_W +: OP_W]; bundle layout (MSB..LSB):
//                            {qNaN, sNaN, inf, zero, sgn, exp[9:0], man[23:0]}
//   rsp_valid / rsp_ready    per-requester result handshake (valid one-hot)
//   rsp_man/exp/sgn/round/sticky/iv   captured multiplier result
//   rsp_err                  result was produced by the watchdog (qNaN)
//   mul_load, mul_op_mul     multiplier strobes, high for the ISSUE cycle only
//   mul_op_a / mul_op_b      latched operands to the multiplier
//   mul_*_y, mul_round_bit, mul_sticky_bit, mul_IV, mul_ready
//                            multiplier result fields and done pulse
//   busy                     high whenever not IDLE
// ---------------------------------------------------------------------------
module float_mul_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int OP_W    = 39,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_op_a,
  input  logic [NUM_REQ*OP_W-1:0] req_op_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [23:0]             rsp_man,
  output logic [9:0]              rsp_exp,
  output logic                    rsp_sgn,
  output logic                    rsp_round,
  output logic                    rsp_sticky,
  output logic                    rsp_iv,
  output logic                    rsp_err,
  output logic                    mul_load,
  output logic                    mul_op_mul,
  output logic [OP_W-1:0]         mul_op_a,
  output logic [OP_W-1:0]         mul_op_b,
  input  logic [23:0]             mul_man_y,
  input  logic [9:0]              mul_exp_y,
  input  logic                    mul_sgn_y,
  input  logic                    mul_round_bit,
  input  logic                    mul_sticky_bit,
  input  logic                    mul_IV,
  input  logic                    mul_ready,
  output logic                    busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CAND_W = IDX_W + 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Canonical quiet NaN returned when the watchdog fires.
  localparam logic [23:0] QNAN_MAN = 24'hC00000;
  localparam logic [9:0]  QNAN_EXP = 10'h0FF;

  logic [1:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_q;
  logic [OP_W-1:0]   op_a_q;
  logic [OP_W-1:0]   op_b_q;
  logic [CNT_W-1:0]  wd_cnt;
  logic [CNT_W-1:0]  wd_next;

  logic [23:0]       man_q;
  logic [9:0]        exp_q;
  logic              sgn_q;
  logic              round_q;
  logic              sticky_q;
  logic              iv_q;
  logic              err_q;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [CAND_W-1:0] cand;

  // Round-robin search starting one past the last grant, wrapping modulo
  // NUM_REQ. The first valid requester found wins.
  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + CAND_W'(i);
      if (cand >= CAND_W'(NUM_REQ)) begin
        cand = cand - CAND_W'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign wd_next = wd_cnt + CNT_W'(1);

  // NOTE: sequential state updates use non-blocking '<=' so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: operand and result registers are reset too, because they drive
      // outputs directly and those must read 0 after reset.
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      wd_cnt   <= '0;
      man_q    <= '0;
      exp_q    <= '0;
      sgn_q    <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      iv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            op_a_q  <= req_op_a[grant_idx*OP_W +: OP_W];
            op_b_q  <= req_op_b[grant_idx*OP_W +: OP_W];
            grant_q <= grant_idx;
            rr_ptr  <= grant_idx;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_ready) begin
            man_q    <= mul_man_y;
            exp_q    <= mul_exp_y;
            sgn_q    <= mul_sgn_y;
            round_q  <= mul_round_bit;
            sticky_q <= mul_sticky_bit;
            iv_q     <= mul_IV;
            err_q    <= 1'b0;
            state    <= S_RESP;
          end else if (wd_next == CNT_W'(TIMEOUT)) begin
            // TIMEOUT cycles spent in WAIT without a ready pulse.
            man_q    <= QNAN_MAN;
            exp_q    <= QNAN_EXP;
            sgn_q    <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            iv_q     <= 1'b0;
            err_q    <= 1'b1;
            state    <= S_RESP;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        S_RESP: begin
          // Only the granted line's rsp_ready can complete the handshake.
          if (rsp_ready[grant_q]) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE && grant_found) ?
                      (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid  = (state == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;

  assign mul_load   = (state == S_ISSUE);
  assign mul_op_mul = (state == S_ISSUE);
  assign mul_op_a   = op_a_q;
  assign mul_op_b   = op_b_q;

  assign rsp_man    = man_q;
  assign rsp_exp    = exp_q;
  assign rsp_sgn    = sgn_q;
  assign rsp_round  = round_q;
  assign rsp_sticky = sticky_q;
  assign rsp_iv     = iv_q;
  assign rsp_err    = err_q;

  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_float_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_float_mul_arbiter
//
// Directed bench for float_mul_arbiter. A behavioural multiplier stub answers
// mul_load (1 cycle for special operands, 5 for normal ones). The stimulus
// pushes hand-computed expected responses into a scoreboard queue; a monitor
// pops and compares whenever rsp_valid rises, and checks hold stability while
// the response is back-pressured.
// ---------------------------------------------------------------------------
module tb_float_mul_arbiter;

  localparam int NUM_REQ = 2;
  localparam int OP_W    = 39;
  localparam int TIMEOUT = 15;

  logic                    clk;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_op_a;
  logic [NUM_REQ*OP_W-1:0] req_op_b;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [23:0]             rsp_man;
  logic [9:0]              rsp_exp;
  logic                    rsp_sgn;
  logic                    rsp_round;
  logic                    rsp_sticky;
  logic                    rsp_iv;
  logic                    rsp_err;
  logic                    mul_load;
  logic                    mul_op_mul;
  logic [OP_W-1:0]         mul_op_a;
  logic [OP_W-1:0]         mul_op_b;
  logic [23:0]             mul_man_y;
  logic [9:0]              mul_exp_y;
  logic                    mul_sgn_y;
  logic                    mul_round_bit;
  logic                    mul_sticky_bit;
  logic                    mul_IV;
  logic                    mul_ready;
  logic                    busy;

  float_mul_arbiter #(
    .NUM_REQ(NUM_REQ),
    .OP_W   (OP_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op_a      (req_op_a),
    .req_op_b      (req_op_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_man       (rsp_man),
    .rsp_exp       (rsp_exp),
    .rsp_sgn       (rsp_sgn),
    .rsp_round     (rsp_round),
    .rsp_sticky    (rsp_sticky),
    .rsp_iv        (rsp_iv),
    .rsp_err       (rsp_err),
    .mul_load      (mul_load),
    .mul_op_mul    (mul_op_mul),
    .mul_op_a      (mul_op_a),
    .mul_op_b      (mul_op_b),
    .mul_man_y     (mul_man_y),
    .mul_exp_y     (mul_exp_y),
    .mul_sgn_y     (mul_sgn_y),
    .mul_round_bit (mul_round_bit),
    .mul_sticky_bit(mul_sticky_bit),
    .mul_IV        (mul_IV),
    .mul_ready     (mul_ready),
    .busy          (busy)
  );

  typedef struct {
    int              r;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [23:0]     man;
    logic [9:0]      ex;
    logic            sg;
    logic            rb;
    logic            st;
    logic            iv;
    logic            er;
    int              due;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   load_cnt = 0;
  bit   in_resp  = 1'b0;
  bit   stub_mute = 1'b0;
  logic [63:0] snap;
  logic [NUM_REQ-1:0] oh;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic logic [OP_W-1:0] mk(input logic q, input logic s,
                                         input logic i, input logic z,
                                         input logic sg, input logic [9:0] e,
                                         input logic [23:0] m);
    return {q, s, i, z, sg, e, m};
  endfunction

  function automatic logic [63:0] rsp_now();
    return {22'b0, rsp_valid, rsp_man, rsp_exp, rsp_sgn, rsp_round,
            rsp_sticky, rsp_iv, rsp_err};
  endfunction

  // Behavioural multiplier: mantissas carry the hidden bit at [23];
  // exponents add without bias removal, +1 when the product overflows 2.0.
  task automatic mul_model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    logic [47:0] p;
    mul_sgn_y      = a[34] ^ b[34];
    mul_round_bit  = 1'b0;
    mul_sticky_bit = 1'b0;
    mul_IV         = 1'b0;
    if (a[35] || b[35]) begin
      mul_man_y = 24'h0;
      mul_exp_y = 10'h0;
    end else if ((|a[38:36]) || (|b[38:36])) begin
      mul_man_y = 24'hC00000;
      mul_exp_y = 10'h0FF;
      mul_IV    = a[37] | b[37];
    end else begin
      p = {24'b0, a[23:0]} * {24'b0, b[23:0]};
      if (p[47]) begin
        mul_man_y      = p[47:24];
        mul_round_bit  = p[23];
        mul_sticky_bit = |p[22:0];
        mul_exp_y      = a[33:24] + b[33:24] + 10'd1;
      end else begin
        mul_man_y      = p[46:23];
        mul_round_bit  = p[22];
        mul_sticky_bit = |p[21:0];
        mul_exp_y      = a[33:24] + b[33:24];
      end
    end
  endtask

  task automatic junk_result();
    mul_man_y      = 24'h5A5A5A;
    mul_exp_y      = 10'h2A5;
    mul_sgn_y      = 1'b1;
    mul_round_bit  = 1'b1;
    mul_sticky_bit = 1'b1;
    mul_IV         = 1'b1;
  endtask

  // Multiplier stub: ready one cycle after load for specials, five for normal.
  initial begin
    logic [OP_W-1:0] a, b;
    bit special;
    mul_ready = 1'b0;
    junk_result();
    forever begin
      @(negedge clk);
      if (mul_load && !reset) begin
        a = mul_op_a;
        b = mul_op_b;
        special = (|a[38:35]) || (|b[38:35]);
        @(posedge clk);
        if (!special) repeat (4) @(posedge clk);
        #1;
        if (!stub_mute) begin
          mul_model(a, b);
          mul_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        mul_ready = 1'b0;
        junk_result();
      end
    end
  end

  // Monitor: pops the scoreboard on each new response, checks hold behaviour.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_resp  = 1'b0;
        load_cnt = 0;
      end else begin
        if (mul_load) begin
          load_cnt++;
          if (sb_q.size() > 0) begin
            check("issue_op_a", mul_op_a, sb_q[0].a);
            check("issue_op_b", mul_op_b, sb_q[0].b);
          end
        end
        if (rsp_valid != '0) begin
          if (!in_resp) begin
            if (sb_q.size() == 0) begin
              check("unexpected_rsp", rsp_valid, '0);
            end else begin
              cur = sb_q.pop_front();
              oh = '0;
              oh[cur.r] = 1'b1;
              check("rsp_cycle",  cyc, cur.due);
              check("rsp_valid",  rsp_valid, oh);
              check("rsp_man",    rsp_man, cur.man);
              check("rsp_exp",    rsp_exp, cur.ex);
              check("rsp_sgn",    rsp_sgn, cur.sg);
              check("rsp_round",  rsp_round, cur.rb);
              check("rsp_sticky", rsp_sticky, cur.st);
              check("rsp_iv",     rsp_iv, cur.iv);
              check("rsp_err",    rsp_err, cur.er);
              check("loads_per_txn", load_cnt, 1);
              snap    = rsp_now();
              in_resp = 1'b1;
            end
          end else begin
            check("hold_rsp_fields", rsp_now(), snap);
            check("hold_no_accept_no_load", {req_ready, mul_load}, '0);
          end
          if (in_resp && rsp_ready[cur.r]) begin
            in_resp  = 1'b0;
            load_cnt = 0;
          end
        end
      end
    end
  end

  task automatic push_exp(input int r, input logic [OP_W-1:0] a,
                          input logic [OP_W-1:0] b, input logic [23:0] man,
                          input logic [9:0] ex, input logic sg, input logic rb,
                          input logic st, input logic iv, input logic er,
                          input int lat);
    exp_t e;
    e.r = r;  e.a = a;  e.b = b;  e.man = man; e.ex = ex;
    e.sg = sg; e.rb = rb; e.st = st; e.iv = iv; e.er = er;
    e.due = cyc + lat;
    sb_q.push_back(e);
  endtask

  // Raise one request, wait for its accept, record the expectation, drop it.
  task automatic start(input int r, input logic [OP_W-1:0] a,
                       input logic [OP_W-1:0] b, input logic [23:0] man,
                       input logic [9:0] ex, input logic sg, input logic rb,
                       input logic st, input logic iv, input logic er,
                       input int lat);
    bit ok;
    req_op_a[r*OP_W +: OP_W] = a;
    req_op_b[r*OP_W +: OP_W] = b;
    req_valid[r] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (req_ready[r]) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_seen", ok, 1'b1);
    if (ok) push_exp(r, a, b, man, ex, sg, rb, st, iv, er, lat);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0 && !in_resp) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("response_done", ok, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, '0);
    check({tag, "_rsp_valid"}, rsp_valid, '0);
    check({tag, "_rsp_fields"}, {rsp_man, rsp_exp, rsp_sgn, rsp_round,
                                 rsp_sticky, rsp_iv, rsp_err}, '0);
    check({tag, "_mul_strobes"}, {mul_load, mul_op_mul}, '0);
    check({tag, "_mul_op_a"}, mul_op_a, '0);
    check({tag, "_mul_op_b"}, mul_op_b, '0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bit ok;
    int order [4];
    logic [NUM_REQ-1:0] exp_g;
    logic [OP_W-1:0] c1a, c1b, c0a, c0b;

    order     = '{1, 0, 1, 0};
    reset     = 1'b1;
    req_valid = '0;
    req_op_a  = '0;
    req_op_b  = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("reset");

    // Contention from reset: req1 = 1.5*1.5 (both negative), req0 = zero*x.
    c1a = mk(0, 0, 0, 0, 1, 10'h07F, 24'hC00000);
    c1b = mk(0, 0, 0, 0, 1, 10'h07F, 24'hC00000);
    c0a = mk(0, 0, 0, 1, 0, 10'h000, 24'h000000);
    c0b = mk(0, 0, 0, 0, 1, 10'h050, 24'h900000);
    req_op_a = {c1a, c0a};
    req_op_b = {c1b, c0b};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        #1;
        if (req_ready != '0) begin
          ok = 1'b1;
          break;
        end
      end
      check("contention_accept", ok, 1'b1);
      exp_g = '0;
      exp_g[order[k]] = 1'b1;
      check("grant_order", req_ready, exp_g);
      if (order[k] == 1)
        push_exp(1, c1a, c1b, 24'h900000, 10'h0FF, 0, 0, 0, 0, 0, 7);
      else
        push_exp(0, c0a, c0b, 24'h000000, 10'h000, 1, 0, 0, 0, 0, 3);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_done();

    // Normal product on requester 0: 1.5 * 1.0.
    start(0, mk(0, 0, 0, 0, 0, 10'h07F, 24'hC00000),
             mk(0, 0, 0, 0, 0, 10'h07F, 24'h800000),
          24'hC00000, 10'h0FE, 0, 0, 0, 0, 0, 7);
    wait_done();

    // Special case on requester 1: zero_a, sign from sgn_a ^ sgn_b.
    start(1, mk(0, 0, 0, 1, 1, 10'h000, 24'h000000),
             mk(0, 0, 0, 0, 0, 10'h080, 24'hA00000),
          24'h000000, 10'h000, 1, 0, 0, 0, 0, 3);
    wait_done();

    // Sticky bit: (1+2^-23)^2, negative * positive.
    start(1, mk(0, 0, 0, 0, 1, 10'h07F, 24'h800001),
             mk(0, 0, 0, 0, 0, 10'h07F, 24'h800001),
          24'h800002, 10'h0FE, 1, 0, 1, 0, 0, 7);
    wait_done();

    // Round bit with 10 cycles of backpressure; requester 1 and a stray
    // rsp_ready[1] are present during the hold and must be ignored.
    rsp_ready[0] = 1'b0;
    start(0, mk(0, 0, 0, 0, 0, 10'h07F, 24'h800001),
             mk(0, 0, 0, 0, 0, 10'h07F, 24'hC00000),
          24'hC00001, 10'h0FE, 0, 1, 0, 0, 0, 7);
    req_op_a[OP_W +: OP_W] = mk(0, 0, 0, 0, 0, 10'h07F, 24'hC00000);
    req_op_b[OP_W +: OP_W] = mk(0, 0, 0, 0, 0, 10'h07F, 24'h800000);
    req_valid[1] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (in_resp) begin
        ok = 1'b1;
        break;
      end
    end
    check("backpressure_rsp_seen", ok, 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    rsp_ready[0] = 1'b1;
    wait_done();

    // Watchdog: no ready pulse, qNaN with rsp_err after TIMEOUT WAIT cycles.
    stub_mute = 1'b1;
    start(1, mk(0, 0, 0, 0, 0, 10'h07F, 24'hC00000),
             mk(0, 0, 0, 0, 1, 10'h07F, 24'h800000),
          24'hC00000, 10'h0FF, 0, 0, 0, 0, 1, 2 + TIMEOUT);
    wait_done();
    stub_mute = 1'b0;

    // Next transaction after the watchdog completes normally.
    start(0, mk(0, 0, 0, 0, 1, 10'h07F, 24'hC00000),
             mk(0, 0, 0, 0, 1, 10'h07F, 24'hC00000),
          24'h900000, 10'h0FF, 0, 0, 0, 0, 0, 7);
    wait_done();

    // Reset during WAIT aborts the transaction with no response.
    start(1, mk(0, 0, 0, 0, 0, 10'h07F, 24'hC00000),
             mk(0, 0, 0, 0, 0, 10'h07F, 24'h800000),
          24'hC00000, 10'h0FE, 0, 0, 0, 0, 0, 7);
    @(posedge clk);
    #1;
    check("busy_in_wait", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    check_reset_outputs("mid_reset");
    repeat (8) @(posedge clk);
    #1;

    // Requests after reset complete with the usual timing.
    start(0, mk(0, 0, 0, 0, 1, 10'h07F, 24'hC00000),
             mk(0, 0, 0, 1, 1, 10'h000, 24'h000000),
          24'h000000, 10'h000, 0, 0, 0, 0, 0, 3);
    wait_done();
    start(1, mk(0, 0, 0, 0, 0, 10'h07F, 24'hC00000),
             mk(0, 0, 0, 0, 0, 10'h07F, 24'h800000),
          24'hC00000, 10'h0FE, 0, 0, 0, 0, 0, 7);
    wait_done();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/float_mul_arbiter.md
Name: float_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-cycle float multiplier datapath between NUM_REQ requesters (e.g. FPU issue port, FMA pre-stage).
- Accepts one unpacked-operand request at a time and drives the multiplier's load/op_mul strobes.
- Waits for the multiplier's one-cycle ready pulse and captures the result.
- Returns the result to the granted requester over a valid/ready handshake.
- Sits between the FPU issue logic and the multiplier instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- OP_W, 39, operand bundle width: {qNaN, sNaN, inf, zero, sgn, exp[9:0], man[23:0]} (MSB..LSB).
- TIMEOUT, 15, maximum cycles in WAIT before the watchdog fires.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_op_a  in  NUM_REQ*OP_W  operand A bundles; requester i occupies [i*OP_W +: OP_W].
- req_op_b  in  NUM_REQ*OP_W  operand B bundles; same packing.
- rsp_valid  out  NUM_REQ  one-hot result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_man  out  24  captured man_y.
- rsp_exp  out  10  captured exp_y.
- rsp_sgn  out  1  captured sgn_y.
- rsp_round  out  1  captured round_bit.
- rsp_sticky  out  1  captured sticky_bit.
- rsp_iv  out  1  captured IV.
- rsp_err  out  1  result produced by the watchdog.
- mul_load  out  1  multiplier load strobe.
- mul_op_mul  out  1  multiplier operation select.
- mul_op_a  out  OP_W  operand A to the multiplier.
- mul_op_b  out  OP_W  operand B to the multiplier.
- mul_man_y  in  24  multiplier result mantissa.
- mul_exp_y  in  10  multiplier result exponent.
- mul_sgn_y  in  1  multiplier result sign.
- mul_round_bit  in  1  multiplier round bit.
- mul_sticky_bit  in  1  multiplier sticky bit.
- mul_IV  in  1  multiplier invalid flag.
- mul_ready  in  1  multiplier done pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; operand and result registers 0.
- Reset mid-operation aborts any transaction with no response. The multiplier shares the same reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from (rr_ptr+1) mod NUM_REQ, with wrap.
  - In that same cycle, assert req_ready[g] for one cycle and latch req_op_a[g], req_op_b[g] and g.
  - Set rr_ptr<=g and go to ISSUE.
- ISSUE:
  - mul_load=1 and mul_op_mul=1 for exactly one cycle.
  - mul_op_a/mul_op_b driven from the latched registers; they stay stable in all non-IDLE states.
  - Go to WAIT.
- WAIT:
  - mul_load=0; the watchdog counter increments each cycle.
  - On mul_ready=1, capture all mul_* result fields, set rsp_err=0, go to RESP.
  - If the counter reaches TIMEOUT with no mul_ready, load a qNaN result (man=0xC00000, exp=0x0FF, sgn=0, round=0, sticky=0, iv=0), set rsp_err=1, go to RESP.
- RESP:
  - rsp_valid[g]=1 and the rsp_* outputs are held stable until rsp_ready[g]=1.
  - rsp_ready on non-granted lines is ignored.
  - On the handshake, go to IDLE. The earliest next accept is the cycle after the handshake.
- Latency, with accept at cycle t:
  - mul_load is high at t+1.
  - Special-case operands: mul_ready at t+2, rsp_valid from t+3.
  - Normal operands: mul_ready at t+6, rsp_valid from t+7.
- mul_load never asserts outside ISSUE, so the multiplier is never reloaded mid-calculation.
- mul_ready seen outside WAIT is ignored.
- A requester dropping req_valid before grant is legal. Payload must be stable while valid.
- Only one transaction is in flight at a time. req_ready is 0 in every state except IDLE.
- Round-robin fairness: a continuously requesting requester is granted within NUM_REQ transactions.

Test Plan:
- Normal product, requester 0: op_a man=0xC00000, op_b man=0x800000, exp_a=exp_b=0x07F, rsp_ready held high.
  -> mul_load at t+1; rsp_valid[0] at t+7; rsp_man=0xC00000, rsp_exp=0x0FE, round=0, sticky=0, rsp_err=0.
- Special case, requester 1: zero_a=1.
  -> rsp_valid[1] at t+3; rsp_man=0, rsp_exp=0, rsp_sgn=sgn_a^sgn_b.
- Contention: both requesters valid continuously for 4 transactions from reset.
  -> grants in order 1,0,1,0; exactly one mul_load per transaction.
- Backpressure: rsp_ready low for 10 cycles after rsp_valid.
  -> rsp_* fields stable, req_ready=0 throughout, no mul_load pulses.
- Watchdog: mul_ready tied low.
  -> rsp_valid at t+2+TIMEOUT with rsp_err=1 and rsp_man=0xC00000; the next transaction proceeds normally.
- Reset asserted during WAIT.
  -> next cycle all outputs 0 and state IDLE; a following request completes with correct timing.
